// File: rtl/unified_mem_arb_pkg.sv
// Shared types and constants for the unified IF/D memory arbiter.
// Holds the read-return owner encoding and word/byte-enable constants.
package unified_mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int         WORD_BYTES = 4;
  localparam int         OFF_W      = $clog2(WORD_BYTES);
  localparam logic [3:0] BE_FULL    = 4'hF;

endpackage

// File: rtl/unified_mem_arb_starve_ctr.sv
// Saturating run counter: counts up on inc_i, clears on clr_i, stops at max_i.
// Ports: clk, rst_n, inc_i, clr_i, max_i -> at_max_o.
module unified_mem_arb_starve_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] max_i,
  output logic         at_max_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max_o = (cnt_q == max_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !at_max_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port sync-read memory between IF and D (D has priority,
// starvation counter forces IF). Optional conflict_cnt via UNIFIED_MEM_ARB_STATS_EN.
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_be,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef UNIFIED_MEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  owner_e owner_q;
  owner_e owner_d;
  logic   at_max;
  logic   unused_addr_lsb;

  // Byte offset within the word is dropped: misaligned accesses truncate.
  assign unused_addr_lsb = ^{if_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  // rst gates grants so nothing reaches memory while held in reset.
  assign d_gnt  = rst & d_req & ~(if_req & at_max);
  assign if_gnt = rst & if_req & (~d_req | at_max);

  unified_mem_arb_starve_ctr #(
    .W (4)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst),
    .inc_i    (d_gnt & if_req),
    .clr_i    (if_gnt | ~if_req),
    .max_i    (4'(STARVE_MAX)),
    .at_max_o (at_max)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (1'b1)
      d_gnt: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr[ADDR_W-1:OFF_W];
        mem_be    = d_we ? d_be : BE_FULL;
        mem_wdata = d_wdata;
      end
      if_gnt: begin
        mem_en   = 1'b1;
        mem_addr = if_addr[ADDR_W-1:OFF_W];
        mem_be   = BE_FULL;
      end
      default: ;
    endcase
  end

  // Stores complete at the grant edge and so never claim the return path.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt)
      owner_d = OWN_IF;
    else if (d_gnt && !d_we)
      owner_d = OWN_D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      owner_q <= OWN_NONE;
    else
      owner_q <= owner_d;
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign d_rvalid  = (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

`ifdef UNIFIED_MEM_ARB_STATS_EN
  logic [15:0] conflict_q;
  logic [15:0] conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (if_req && d_req && conflict_q != 16'hFFFF)
      conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      conflict_q <= '0;
    else
      conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a behavioural sync-read memory.
// Directed stimulus pushes expected read returns; a monitor pops on rvalid.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [7:0]  d_addr = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
`ifdef UNIFIED_MEM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  int total = 0;
  int passed = 0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] mem[64];

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W(8), .DATA_W(32), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef UNIFIED_MEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // Behavioural single-port synchronous-read memory
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: compare returned read data against scoreboard queues
  always @(negedge clk) begin
    if (if_rvalid) begin
      if (if_q.size() == 0) begin
        total++;
        $display("FAIL if_rvalid_unexpected: got 1 expected 0");
      end else begin
        chk("if_rdata", if_rdata, if_q.pop_front());
      end
      chk("d_rvalid_excl", {31'd0, d_rvalid}, 32'd0);
      chk("d_rdata_zero", d_rdata, 32'd0);
    end
    if (d_rvalid) begin
      if (d_q.size() == 0) begin
        total++;
        $display("FAIL d_rvalid_unexpected: got 1 expected 0");
      end else begin
        chk("d_rdata", d_rdata, d_q.pop_front());
      end
      chk("if_rdata_zero", if_rdata, 32'd0);
    end
  end

  task automatic idle();
    @(negedge clk);
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  logic exp_d;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = 32'h1234_5678;
    mem[3] = 32'hAABB_CCDD;
    mem[4] = 32'h0011_81b3;

    repeat (2) @(negedge clk);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b1;
    idle();

    // IF-only read
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h10;
    #1;
    chk("if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("if_only_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("if_mem_en", {31'd0, mem_en}, 32'd1);
    chk("if_mem_we", {31'd0, mem_we}, 32'd0);
    chk("if_mem_addr", {26'd0, mem_addr}, 32'd4);
    chk("if_mem_be", {28'd0, mem_be}, 32'hF);
    if_q.push_back(32'h0011_81b3);
    idle();

    // D store: partial byte enables
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h0C;
    d_be = 4'b0011; d_wdata = 32'h0000_0015;
    #1;
    chk("st_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_be", {28'd0, mem_be}, 32'h3);
    chk("st_mem_addr", {26'd0, mem_addr}, 32'd3);
    chk("st_mem_wdata", mem_wdata, 32'h15);
    idle();

    // D load of stored word: only low two bytes replaced
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h0C;
    #1;
    chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
    chk("ld_mem_be", {28'd0, mem_be}, 32'hF);
    d_q.push_back(32'hAABB_0015);
    idle();

    // Conflict: D wins
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h04;
    #1;
    chk("cf_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("cf_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("cf_mem_addr", {26'd0, mem_addr}, 32'd1);
    d_q.push_back(32'h1234_5678);
    idle();

    // No request: memory port quiet
    #1;
    chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
    chk("idle_mem_be", {28'd0, mem_be}, 32'd0);
    chk("idle_mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("idle_mem_wdata", mem_wdata, 32'd0);

    // Starvation: D,D,D,D,IF,D
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 8'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h04;
      #1;
      exp_d = (i != 4);
      chk($sformatf("sv_d_gnt%0d", i), {31'd0, d_gnt}, {31'd0, exp_d});
      chk($sformatf("sv_if_gnt%0d", i), {31'd0, if_gnt}, {31'd0, !exp_d});
      if (exp_d) d_q.push_back(32'h1234_5678);
      else if_q.push_back(32'h0011_81b3);
    end
    idle();

`ifdef UNIFIED_MEM_ARB_STATS_EN
    chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd7);
`endif

    // Misaligned fetch address truncates
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h13;
    #1;
    chk("mis_mem_addr", {26'd0, mem_addr}, 32'd4);
    if_q.push_back(32'h0011_81b3);
    idle();
    repeat (2) @(negedge clk);

    // Reset with a fetch in flight
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h10;
    #1;
    chk("rr_if_gnt", {31'd0, if_gnt}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rr_gnt_gated", {31'd0, if_gnt}, 32'd0);
    chk("rr_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rr_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rr_if_rdata", if_rdata, 32'd0);
    @(negedge clk);
    if_req = 1'b0;
    chk("rr_if_rvalid2", {31'd0, if_rvalid}, 32'd0);
`ifdef UNIFIED_MEM_ARB_STATS_EN
    chk("rr_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rr_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);

    chk("if_q_drained", if_q.size(), 32'd0);
    chk("d_q_drained", d_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
